// File: rtl/mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_responder_pkg : shared types and constants for the memory responder
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 16
`endif
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif

package mem_responder_pkg;

  localparam int MEM_DATA_W   = `MEM_BANDWIDTH * 8;
  localparam int MEM_ADDR_W   = `MEM_ADDR_SIZE;
  localparam int READ_LAT_MAX = 8;

  typedef enum logic [1:0] {
    MEM_ERR_NONE          = 2'd0,
    MEM_ERR_RANGE         = 2'd1,
    MEM_ERR_RW_CONFLICT   = 2'd2,
    MEM_ERR_INIT_CONFLICT = 2'd3
  } mem_err_code_t;

  typedef struct packed {
    logic                  valid;
    logic [MEM_DATA_W-1:0] data;
  } mem_resp_pipe_packet_t;

endpackage

`default_nettype wire

// File: rtl/mem_resp_pipe.sv
// ----------------------------------------------------------------------------
// mem_resp_pipe : DEPTH-stage valid/data shift register with async clear
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mem_resp_pipe
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  mem_resp_pipe_packet_t in_pkt,
  output mem_resp_pipe_packet_t out_pkt
);

  mem_resp_pipe_packet_t stage [DEPTH];

  // Data only advances alongside a valid bit, so the last stage holds the
  // most recently returned line while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].valid <= in_pkt.valid;
      if (in_pkt.valid) begin
        stage[0].data <= in_pkt.data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        stage[i].valid <= stage[i-1].valid;
        if (stage[i-1].valid) begin
          stage[i].data <= stage[i-1].data;
        end
      end
    end
  end

  assign out_pkt = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder : word-addressed store with fixed-latency pipelined reads,
// backdoor init port and sticky error capture. Optional MEM_RESP_STATS_EN
// adds saturating read/write counters. Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W     = MEM_DATA_W,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_write_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_W-1:0]     mem_read_data,
  output logic                  mem_valid,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [DATA_W-1:0]     init_data,
  output logic                  err,
  output logic [1:0]            err_code
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
`endif
);

  localparam int OFF       = $clog2(DATA_W / 8);
  localparam int LINE_TOP  = OFF + DEPTH_LOG2;
  localparam int PIPE_DEPTH = (READ_LAT < 1) ? 1 :
                              (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

  logic [DATA_W-1:0]     store [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] line;
  logic                  out_of_range;
  logic                  write_go;
  logic                  read_go;
  logic                  init_go;
  logic                  unused_low_bits;
  mem_err_code_t         cause;
  mem_err_code_t         err_cause;
  mem_resp_pipe_packet_t pipe_in;
  mem_resp_pipe_packet_t pipe_out;

  assign line            = mem_addr[LINE_TOP-1:OFF];
  assign out_of_range    = |mem_addr[ADDR_W-1:LINE_TOP];
  assign unused_low_bits = ^mem_addr[OFF-1:0];

  // A write always wins over a simultaneous read; init yields to any request.
  assign write_go = mem_write & ~out_of_range;
  assign read_go  = mem_read & ~mem_write;
  assign init_go  = init_we & ~mem_read & ~mem_write;

  always_ff @(posedge clk) begin
    if (write_go) begin
      store[line] <= mem_write_data;
    end else if (init_go) begin
      store[init_addr] <= init_data;
    end
  end

  always_comb begin
    cause = MEM_ERR_NONE;
    if ((mem_read | mem_write) & out_of_range) begin
      cause = MEM_ERR_RANGE;
    end else if (mem_read & mem_write) begin
      cause = MEM_ERR_RW_CONFLICT;
    end else if (init_we & (mem_read | mem_write)) begin
      cause = MEM_ERR_INIT_CONFLICT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_cause <= MEM_ERR_NONE;
    end else if (!err && cause != MEM_ERR_NONE) begin
      err       <= 1'b1;
      err_cause <= cause;
    end
  end

  assign err_code = err_cause;

  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = read_go;
    pipe_in.data  = out_of_range ? '0 : store[line];
  end

  mem_resp_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_pkt  (pipe_in),
    .out_pkt (pipe_out)
  );

  assign mem_valid     = pipe_out.valid;
  assign mem_read_data = pipe_out.data;

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (read_go && rd_count != '1) begin
        rd_count <= rd_count + 32'd1;
      end
      if (write_go && wr_count != '1) begin
        wr_count <= wr_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
